// File: rtl/wave_display_if.sv
// Raster-in / pixel-out bus of the waveform display, plus its sample-RAM read port.
// The master side drives the raster and returns RAM data; the slave side is the display.
interface wave_display_if;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        wave_display_idle;

  modport master (
    output x, y, valid, read_index, read_value,
    input  read_address, valid_pixel, r, g, b, wave_display_idle
  );

  modport slave (
    input  x, y, valid, read_index, read_value,
    output read_address, valid_pixel, r, g, b, wave_display_idle
  );
endinterface

// File: rtl/wave_display.sv
// Draws the captured 512x8 sample RAM as a vertically filled trace in the top-left 1024x512 window.
// Define WAVE_DISPLAY_GRID_EN to overlay grid lines every 128 pixels.
module wave_display #(
  parameter logic [23:0] WAVE_COLOR = 24'hFFFFFF,
  parameter logic [23:0] GRID_COLOR = 24'h404040
) (
  input logic           clk,
  input logic           reset,
  wave_display_if.slave bus
);

  function automatic logic in_span(input logic [7:0] row, input logic [7:0] a,
                                   input logic [7:0] b);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    return (row >= lo) && (row <= hi);
  endfunction

  // Stage 0: address the RAM and capture the pixel position
  logic inwin_p0;
  assign inwin_p0         = bus.valid & ~bus.x[10] & ~bus.y[9];
  assign bus.read_address = {bus.read_index, bus.x[9:2]};

  logic       vld_p1;
  logic       inwin_p1;
  logic [7:0] addr_p1;
  logic [7:0] yr_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      inwin_p1 <= 1'b0;
    end else begin
      vld_p1   <= bus.valid;
      inwin_p1 <= inwin_p0;
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= bus.x[9:2];
    yr_p1   <= bus.y[8:1];
  end

  logic grid_p1;
`ifdef WAVE_DISPLAY_GRID_EN
  logic [6:0] xg_p1;
  logic [6:0] yg_p1;

  always_ff @(posedge clk) begin
    xg_p1 <= bus.x[6:0];
    yg_p1 <= bus.y[6:0];
  end

  assign grid_p1 = inwin_p1 & ((xg_p1 == 7'd0) | (yg_p1 == 7'd0));
`else
  assign grid_p1 = 1'b0;
`endif

  // Stage 1: RAM data arrives; decide whether this row lies on the trace segment
  logic [7:0]  last_addr;
  logic [7:0]  hold_cur;
  logic [7:0]  hold_prev;
  logic        new_addr_p1;
  logic [7:0]  cur_p1;
  logic [7:0]  prev_p1;
  logic        lit_p1;
  logic [23:0] rgb_p1;

  always_comb begin
    new_addr_p1 = vld_p1 & inwin_p1 & ((addr_p1 != last_addr) | (addr_p1 == 8'd0));
    cur_p1      = hold_cur;
    prev_p1     = hold_prev;
    if (new_addr_p1) begin
      cur_p1  = bus.read_value;
      // Column 0 starts a fresh line: no fill from the previous line's last sample
      prev_p1 = (addr_p1 == 8'd0) ? bus.read_value : hold_cur;
    end
    lit_p1 = inwin_p1 & in_span(yr_p1, ~cur_p1, ~prev_p1);
    rgb_p1 = lit_p1 ? WAVE_COLOR : (grid_p1 ? GRID_COLOR : 24'h000000);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr <= 8'd0;
      hold_cur  <= 8'd0;
      hold_prev <= 8'd0;
    end else if (new_addr_p1) begin
      last_addr <= addr_p1;
      hold_cur  <= cur_p1;
      hold_prev <= prev_p1;
    end
  end

  // Stage 2: registered pixel outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.valid_pixel <= 1'b0;
      bus.r           <= 8'd0;
      bus.g           <= 8'd0;
      bus.b           <= 8'd0;
    end else begin
      bus.valid_pixel <= vld_p1 & (lit_p1 | grid_p1);
      bus.r           <= rgb_p1[23:16];
      bus.g           <= rgb_p1[15:8];
      bus.b           <= rgb_p1[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wave_display_idle <= 1'b0;
    end else if (bus.valid) begin
      bus.wave_display_idle <= bus.y[9];
    end
  end

endmodule

// File: doc/wave_display.md
Name: wave_display

Overview:
- Downstream consumer of the 512-entry, 8-bit sample RAM written by the wave capture stage.
- Takes the raster pixel stream (x, y, valid) from the VGA timing block and issues RAM reads from the half selected by read_index.
- Outputs a lit/unlit pixel with colour for the waveform trace, drawn as a connected vertical-fill line.
- Asserts wave_display_idle while the raster is outside the drawing window, so the capture stage may swap RAM halves.

Parameters:
- WAVE_COLOR, 24'hFFFFFF, {r,g,b} colour of the waveform trace.
- GRID_COLOR, 24'h404040, {r,g,b} colour of grid lines (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- x  input  11  current raster column, 0..1279
- y  input  10  current raster row, 0..1023
- valid  input  1  x/y describe a visible pixel this cycle
- read_index  input  1  RAM half currently owned by the display
- read_value  input  8  RAM data, valid one cycle after read_address
- read_address  output  9  {read_index, x[9:2]}, combinational from inputs
- valid_pixel  output  1  pixel is lit (trace or grid)
- r  output  8  red
- g  output  8  green
- b  output  8  blue
- wave_display_idle  output  1  raster outside drawing window

Behaviour:
- Reset is asynchronous, active-high. All registers clear on reset: valid_pixel=0, r=g=b=0, wave_display_idle=0, last_addr=0, hold_cur=0, hold_prev=0.
- Drawing window: valid & ~x[10] & ~y[9], i.e. x 0..1023, y 0..511.
- Each sample spans 4 columns (addr = x[9:2]). Trace row index = y[8:1], so each sample row is 2 pixels tall. Target row for sample v = ~v (255-v), so v=255 plots at the top.
- Stage 0, cycle n:
  - read_address = {read_index, x[9:2]}, driven combinationally.
  - Register valid1, inwin1, addr1=x[9:2], yr1=y[8:1], and x1[6:0] / y1[6:0] for the grid.
- Stage 1, cycle n+1 (read_value is the sample for addr1):
  - new_addr = valid1 & inwin1 & (addr1 != last_addr | addr1 == 0).
  - cur = new_addr ? read_value : hold_cur.
  - prev = new_addr ? (addr1==0 ? read_value : hold_cur) : hold_prev.
  - On new_addr, register hold_cur<=cur, hold_prev<=prev, last_addr<=addr1.
  - lit = inwin1 & min(~cur,~prev) <= yr1 <= max(~cur,~prev), all comparisons unsigned 8-bit.
- Output registers, visible at cycle n+2:
  - valid_pixel <= valid1 & lit.
  - {r,g,b} <= lit ? WAVE_COLOR : 0.
  - Total latency from x/y/valid to pixel outputs is exactly 2 cycles.
- Column 0 of each line loads prev=cur, so there is no vertical fill carried over from the previous line's last sample.
- Repeated addresses (the 4 columns of one sample) reuse the held cur/prev; identical samples give a single 2-pixel-tall dot per column.
- Cycles with valid=0 (blanking) do not disturb hold_cur, hold_prev, or last_addr.
- wave_display_idle:
  - Registered; set to 1 on any cycle with valid & y[9].
  - Cleared on any cycle with valid & ~y[9].
  - Holds its value when valid=0.
- read_index is used as-is with no internal latching. The capture stage only toggles it while wave_display_idle=1, so the RAM half never changes within the drawing window.
- Reset mid-frame: outputs drop to 0 immediately. Drawing resumes correctly from the next column 0 after reset releases.

Optional Feature:
- Macro: WAVE_DISPLAY_GRID_EN.
- Defined: inside the window, pixels with x1[6:0]==0 or y1[6:0]==0 that are not trace-lit output valid_pixel=1 with GRID_COLOR. The trace has priority over the grid.
- Undefined: no grid logic is built; only the trace lights pixels.

Test Plan:
- RAM half 0 all 8'd128, read_index=0, raster line y=254 and y=256 -> read_address stays in 0..255. Lit (valid_pixel=1, rgb=FFFFFF) on y=254/255 for all x 0..1023. Unlit at y=256. Output exactly 2 cycles after the input pixel.
- Sample[0]=8'd255, sample[1]=8'd0, sweep y -> at x=4..7 all rows y=0..511 lit (fill from ~255=0 to ~0=255). At x=0..3 only y=0..1 lit.
- read_index=1, x=1023 -> read_address=9'h1FF. x=1024..1279 -> never lit.
- Raster y goes 511 -> 512 with valid=1 -> wave_display_idle rises 1 cycle later. Back to y=0 -> falls. valid=0 during blanking -> value holds.
- Reset asserted mid-line with a lit pixel in flight -> valid_pixel, r, g, b go to 0 without waiting for a clock edge. After release, the first line's column 0 draws no fill from stale hold_cur.
- With WAVE_DISPLAY_GRID_EN, all samples 8'd0 -> pixel (128,64) grey 404040. Pixel (x, 510..511) trace white, overriding grid at x=128.
